multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath. Sequences one instruction over 3-5 states, plus memory wait states.
- Drives the register, memory and PC enables and the mux selects.
- Supplies the 3-bit ALUop consumed by the ALU control decoder: 000 add, 001 sub, 010 R-type by func, 011 addi, 100 andi.
- Sits between the instruction register (opcode source), the unified memory (mem_ready handshake) and the shared ALU.

---
 rtl/multicycle_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_controller #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [2:0]         ALUop,
    output logic               illegal_op,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11,
        ANDIEX = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    state_t             cur;
    state_t             nxt;
    logic [5:0]         op_q;
    logic [COUNT_W-1:0] cnt;
    logic               retire;

    logic               is_r;
    logic               is_mem;
    logic               is_beq;
    logic               is_j;
    logic               is_addi;
    logic               is_andi;
    logic               q_lw;
    logic               q_sw;

    logic               pcw;
    logic               pcwc;
    logic               mrd;
    logic               mwr;
    logic               irw;
    logic               rgw;
    logic               ill;

    assign is_r    = (opcode == OP_R);
    assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_j    = (opcode == OP_J);
    assign is_addi = (opcode == OP_ADDI);
    assign is_andi = (opcode == OP_ANDI);

    // MEMADR runs after the IR may have moved on, so it uses the copy taken in DECODE
    assign q_lw = (op_q == OP_LW);
    assign q_sw = (op_q == OP_SW);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= FETCH;
            op_q <= 6'd0;
            cnt  <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        nxt      = FETCH;
        retire   = 1'b0;
        pcw      = 1'b0;
        pcwc     = 1'b0;
        mrd      = 1'b0;
        mwr      = 1'b0;
        irw      = 1'b0;
        rgw      = 1'b0;
        ill      = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        ALUop    = 3'b000;
        case (cur)
            FETCH: begin
                mrd     = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    irw = 1'b1;
                    pcw = 1'b1;
                    nxt = DECODE;
                end else begin
                    nxt = FETCH;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                unique case (1'b1)
                    is_r:    nxt = EXEC;
                    is_mem:  nxt = MEMADR;
                    is_beq:  nxt = BRANCH;
                    is_j:    nxt = JUMP;
                    is_addi: nxt = ADDIEX;
                    is_andi: nxt = ANDIEX;
                    default: begin
                        nxt = FETCH;
                        ill = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                unique case (1'b1)
                    q_lw:    nxt = MEMRD;
                    q_sw:    nxt = MEMWR;
                    default: nxt = FETCH;
                endcase
            end
            MEMRD: begin
                IorD = 1'b1;
                mrd  = 1'b1;
                nxt  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                rgw      = 1'b1;
                retire   = 1'b1;
                nxt      = FETCH;
            end
            MEMWR: begin
                IorD = 1'b1;
                mwr  = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    nxt    = FETCH;
                end else begin
                    nxt = MEMWR;
                end
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 3'b010;
                nxt     = ALUWB;
            end
            ALUWB: begin
                RegDst = 1'b1;
                rgw    = 1'b1;
                retire = 1'b1;
                nxt    = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUop   = 3'b001;
                pcwc    = 1'b1;
                PCSrc   = 2'b01;
                retire  = 1'b1;
                nxt     = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 3'b011;
                nxt     = IMMWB;
            end
            IMMWB: begin
                rgw    = 1'b1;
                retire = 1'b1;
                nxt    = FETCH;
            end
            JUMP: begin
                pcw    = 1'b1;
                PCSrc  = 2'b10;
                retire = 1'b1;
                nxt    = FETCH;
            end
            ANDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = 3'b100;
                nxt     = IMMWB;
            end
            default: nxt = FETCH;
        endcase
    end

    // Reset kills every write strobe immediately, even mid-access
    assign PCWrite     = pcw  & ~rst;
    assign PCWriteCond = pcwc & ~rst;
    assign MemRead     = mrd  & ~rst;
    assign MemWrite    = mwr  & ~rst;
    assign IRWrite     = irw  & ~rst;
    assign RegWrite    = rgw  & ~rst;
    assign illegal_op  = ill  & ~rst;

    assign state       = cur;
    assign instr_count = cnt;

    logic unused_zero;
    assign unused_zero = zero;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, corner
// sequences and a randomized run against an instruction-path reference model.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUop;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_controller #(.COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUop(ALUop), .illegal_op(illegal_op),
        .state(state), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
    } out_t;

    typedef struct {
        logic [5:0] op;
        int         fstall;
        int         mstall;
        int         cycles;
        int         retired;
        int         illegal;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_state;
    logic [31:0] m_count;
    int          m_path[$];
    int          ill_seen;
    logic [5:0]  legal_ops[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // State sequence after DECODE for each instruction class
    task automatic set_path(input logic [5:0] op);
        m_path.delete();
        case (op)
            6'b000000: m_path = {6, 7};
            6'b100011: m_path = {2, 3, 4};
            6'b101011: m_path = {2, 5};
            6'b000100: m_path = {8};
            6'b000010: m_path = {11};
            6'b001000: m_path = {9, 10};
            6'b001100: m_path = {12, 10};
            default:   m_path.delete();
        endcase
    endtask

    function automatic out_t exp_outs(input int st, input logic rdy, input logic r);
        out_t o;
        o = '0;
        case (st)
            0: begin
                o.mr = 1; o.srcb = 2'b01;
                if (rdy) begin o.irw = 1; o.pcw = 1; end
            end
            1: o.srcb = 2'b11;
            2: begin o.srca = 1; o.srcb = 2'b10; end
            3: begin o.iord = 1; o.mr = 1; end
            4: begin o.m2r = 1; o.rw = 1; end
            5: begin o.iord = 1; o.mw = 1; end
            6: begin o.srca = 1; o.aluop = 3'b010; end
            7: begin o.rdst = 1; o.rw = 1; end
            8: begin o.srca = 1; o.aluop = 3'b001; o.pcwc = 1; o.pcsrc = 2'b01; end
            9: begin o.srca = 1; o.srcb = 2'b10; o.aluop = 3'b011; end
            10: o.rw = 1;
            11: begin o.pcw = 1; o.pcsrc = 2'b10; end
            12: begin o.srca = 1; o.srcb = 2'b10; o.aluop = 3'b100; end
            default: o = '0;
        endcase
        if (r) begin
            o.pcw = 0; o.pcwc = 0; o.mr = 0; o.mw = 0; o.irw = 0; o.rw = 0;
        end
        return o;
    endfunction

    task automatic advance();
        if (m_path.size() > 0) begin
            m_state = m_path.pop_front();
        end else begin
            m_state = 0;
            m_count = m_count + 1;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0;
            m_count = 0;
            m_path.delete();
        end else begin
            case (m_state)
                0: if (mem_ready) m_state = 1;
                1: begin
                    if (legal(opcode)) begin
                        set_path(opcode);
                        m_state = m_path.pop_front();
                    end else begin
                        m_state = 0;
                    end
                end
                3, 5: if (mem_ready) advance();
                default: advance();
            endcase
        end
    endtask

    task automatic check_cycle();
        out_t act;
        logic exp_ill;
        act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUop};
        exp_ill = !rst && (m_state == 1) && !legal(opcode);
        chk("state", {28'd0, state}, m_state);
        chk("outputs", {15'd0, act}, {15'd0, exp_outs(m_state, mem_ready, rst)});
        chk("illegal_op", {31'd0, illegal_op}, {31'd0, exp_ill});
        chk("instr_count", instr_count, m_count);
        if (illegal_op === 1'b1) ill_seen++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_instr(input vec_t v, output int cycles);
        int  fs;
        int  ms;
        bit  left;
        fs     = v.fstall;
        ms     = v.mstall;
        left   = 0;
        cycles = 0;
        rst    = 1'b0;
        while (cycles < 40) begin
            if (m_state == 0 || m_state == 1) opcode = v.op;
            else opcode = 6'($urandom);
            if (m_state == 0) begin
                mem_ready = (fs > 0) ? 1'b0 : 1'b1;
                if (fs > 0) fs--;
            end else if (m_state == 3 || m_state == 5) begin
                mem_ready = (ms > 0) ? 1'b0 : 1'b1;
                if (ms > 0) ms--;
            end else begin
                mem_ready = 1'($urandom);
            end
            tick();
            cycles++;
            if (m_state != 0) left = 1;
            if (left && m_state == 0) break;
        end
        if (cycles >= 40) chk("instr_timeout", 32'(cycles), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int          cyc;
        int          total;
        logic [31:0] c0;
        int          i0;

        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b001000, 6'b001100};

        vecs[0]  = '{6'b000000, 0, 0, 4, 1, 0};
        vecs[1]  = '{6'b100011, 0, 3, 8, 1, 0};
        vecs[2]  = '{6'b000100, 0, 0, 3, 1, 0};
        vecs[3]  = '{6'b000010, 0, 0, 3, 1, 0};
        vecs[4]  = '{6'b001000, 0, 0, 4, 1, 0};
        vecs[5]  = '{6'b001100, 0, 0, 4, 1, 0};
        vecs[6]  = '{6'b111111, 0, 0, 2, 0, 1};
        vecs[7]  = '{6'b100011, 0, 0, 5, 1, 0};
        vecs[8]  = '{6'b101011, 0, 0, 4, 1, 0};
        vecs[9]  = '{6'b101011, 0, 2, 6, 1, 0};
        vecs[10] = '{6'b000000, 2, 0, 6, 1, 0};
        vecs[11] = '{6'b010101, 1, 0, 3, 0, 1};

        zero      = 1'b0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        @(posedge clk);
        model_step();
        #1;

        // reset held two cycles
        tick();
        tick();
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_count", instr_count, 32'd0);

        rst       = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        #1;
        chk("post_reset_fetch", {29'd0, MemRead, IRWrite, PCWrite}, 32'd7);

        // vector table
        total = 0;
        for (int i = 0; i < 12; i++) begin
            c0 = instr_count;
            i0 = ill_seen;
            run_instr(vecs[i], cyc);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            chk($sformatf("vec%0d_retired", i), instr_count - c0, 32'(vecs[i].retired));
            chk($sformatf("vec%0d_illegal", i), 32'(ill_seen - i0), 32'(vecs[i].illegal));
            if (i >= 2 && i <= 5) total += cyc;
        end
        chk("beq_j_addi_andi_cycles", 32'(total), 32'd14);

        // reset during a stalled store
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        cyc       = 0;
        while (m_state != 5 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("reach_memwr", {28'd0, state}, 32'd5);
        mem_ready = 1'b0;
        tick();
        chk("memwr_held", {31'd0, MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("memwr_drop_on_rst", {31'd0, MemWrite}, 32'd0);
        tick();
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_to_fetch", {28'd0, state}, 32'd0);
        chk("rst_count_clear", instr_count, 32'd0);

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(99) == 0);
            mem_ready = ($urandom_range(3) != 0);
            if (m_state == 0) begin
                if ($urandom_range(9) < 8) opcode = legal_ops[$urandom_range(6)];
                else opcode = 6'($urandom);
            end else if (m_state != 1) begin
                opcode = 6'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
